// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: enable/flush sequencer for a 5-stage pipeline (load-use, branch, memory wait, debug step).
// Define PIPE_PERF_CNT_EN to build the stall/flush performance counters.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic             rs1_used_ID,
  input  logic             rs2_used_ID,
  input  logic [4:0]       rd_EX,
  input  logic             mem_read_EX,
  input  logic             br_taken_EX,
  input  logic             mem_req_MEM,
  input  logic             mem_ready_MEM,
  input  logic             step_mode,
  input  logic             step_go,
  output logic             en_PC,
  output logic             en_IF_ID,
  output logic             en_ID_EX,
  output logic             en_EX_MEM,
  output logic             en_MEM_WB,
  output logic             flush_IF_ID,
  output logic             flush_ID_EX,
  output logic             flush_MEM_WB,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT, STEP} state_e;
  state_e state_q, state_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic [8:0] wcnt_inc;
  logic mem_err_q, mem_err_d, go_q;
  logic load_use, mem_stall, stall_now, timeout, go_rise, act, adv;
  assign load_use = mem_read_EX && rd_EX != 5'd0 &&
                    ((rs1_used_ID && rs1_ID == rd_EX) || (rs2_used_ID && rs2_ID == rd_EX));
  assign mem_stall = mem_req_MEM && !mem_ready_MEM;
  // Once waiting, only the ready strobe releases the stall.
  assign stall_now = (state_q == MEM_WAIT) ? !mem_ready_MEM : (state_q != HALT) && mem_stall;
  assign wcnt_inc = (state_q == MEM_WAIT) ? {1'b0, wcnt_q} + 9'd1 : 9'd1;
  assign timeout = wcnt_inc >= 9'(MEM_TIMEOUT);
  assign go_rise = step_go && !go_q;
  assign act = !rst && state_q != HALT;
  assign adv = act && !stall_now;
  assign en_PC = adv && (br_taken_EX || !load_use);
  assign en_IF_ID = en_PC;
  assign en_ID_EX = adv;
  assign en_EX_MEM = adv;
  assign en_MEM_WB = act;
  assign flush_IF_ID = adv && br_taken_EX;
  assign flush_ID_EX = adv && (br_taken_EX || load_use);
  assign flush_MEM_WB = act && stall_now;
  assign halted = state_q == HALT;
  assign mem_err = mem_err_q;
  always_comb begin
    state_d = state_q;
    wcnt_d = wcnt_q;
    mem_err_d = mem_err_q;
    if (state_q == HALT)
      state_d = mem_err_q ? HALT : !step_mode ? RUN : go_rise ? STEP : HALT;
    else if (stall_now) begin
      wcnt_d = wcnt_inc[7:0];
      mem_err_d = mem_err_q || timeout;
      state_d = timeout ? HALT : MEM_WAIT;
    end else
      state_d = (step_mode || state_q == STEP) ? HALT : RUN;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      wcnt_q <= '0;
      mem_err_q <= 1'b0;
      go_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q <= wcnt_d;
      mem_err_q <= mem_err_d;
      go_q <= step_go;
    end
  end
`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!en_PC && state_q != HALT) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_IF_ID || flush_ID_EX) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and random checks of pipe_hazard_ctrl against a behavioural model.
module tb_pipe_hazard_ctrl;
  localparam int TO = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] rs1_ID, rs2_ID, rd_EX;
  logic rs1_used_ID, rs2_used_ID, mem_read_EX, br_taken_EX, mem_req_MEM, mem_ready_MEM, step_mode, step_go;
  logic en_PC, en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB, flush_IF_ID, flush_ID_EX, flush_MEM_WB, halted, mem_err;
  logic [31:0] stall_cnt, flush_cnt;
  int vecs = 0, errs = 0, pc_hits = 0;
  bit m_halt, m_wait, m_step, m_err, m_prev_go;
  int m_waited;
  logic [31:0] m_sc, m_fc;
  localparam int K_IDLE = 0, K_STALL = 1, K_BR = 2, K_LU = 3, K_NORM = 4;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rs1_used_ID(rs1_used_ID),
    .rs2_used_ID(rs2_used_ID), .rd_EX(rd_EX), .mem_read_EX(mem_read_EX), .br_taken_EX(br_taken_EX),
    .mem_req_MEM(mem_req_MEM), .mem_ready_MEM(mem_ready_MEM), .step_mode(step_mode), .step_go(step_go),
    .en_PC(en_PC), .en_IF_ID(en_IF_ID), .en_ID_EX(en_ID_EX), .en_EX_MEM(en_EX_MEM), .en_MEM_WB(en_MEM_WB),
    .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX), .flush_MEM_WB(flush_MEM_WB),
    .halted(halted), .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    {rs1_ID, rs2_ID, rd_EX} = '0;
    {rs1_used_ID, rs2_used_ID, mem_read_EX, br_taken_EX, mem_req_MEM, mem_ready_MEM} = '0;
  endtask

  task automatic m_reset();
    {m_halt, m_wait, m_step, m_err, m_prev_go} = '0;
    m_waited = 0;
    m_sc = '0;
    m_fc = '0;
  endtask

  function automatic int m_kind();
    bit lu, stall;
    lu = mem_read_EX && rd_EX != 0 && ((rs1_used_ID && rs1_ID == rd_EX) || (rs2_used_ID && rs2_ID == rd_EX));
    stall = m_wait ? !mem_ready_MEM : (mem_req_MEM && !mem_ready_MEM);
    if (m_halt) return K_IDLE;
    if (stall) return K_STALL;
    if (br_taken_EX) return K_BR;
    if (lu) return K_LU;
    return K_NORM;
  endfunction

  // Bits: en_PC en_IF_ID en_ID_EX en_EX_MEM en_MEM_WB flush_IF_ID flush_ID_EX flush_MEM_WB
  task automatic cyc(input string tag);
    int k;
    logic [7:0] exp, msk, obs;
    bit rise;
    #1;
    k = m_kind();
    exp = (k == K_STALL) ? 8'b0000_1001 : (k == K_BR) ? 8'b1111_1110 :
          (k == K_LU) ? 8'b0001_1010 : (k == K_NORM) ? 8'b1111_1000 : 8'b0;
    msk = (k == K_LU) ? 8'b1101_1111 : 8'hff;
    obs = {en_PC, en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB, flush_IF_ID, flush_ID_EX, flush_MEM_WB};
    if (en_PC) pc_hits++;
    chk({tag, "_ctl"}, 64'(obs & msk), 64'(exp & msk));
    chk({tag, "_halted"}, 64'(halted), 64'(m_halt));
    chk({tag, "_mem_err"}, 64'(mem_err), 64'(m_err));
`ifdef PIPE_PERF_CNT_EN
    chk({tag, "_stall_cnt"}, 64'(stall_cnt), 64'(m_sc));
    chk({tag, "_flush_cnt"}, 64'(flush_cnt), 64'(m_fc));
`else
    chk({tag, "_stall_cnt"}, 64'(stall_cnt), 64'd0);
    chk({tag, "_flush_cnt"}, 64'(flush_cnt), 64'd0);
`endif
    if (k == K_STALL || k == K_LU) m_sc++;
    if (k == K_BR || k == K_LU) m_fc++;
    rise = step_go && !m_prev_go;
    m_prev_go = step_go;
    if (m_halt) begin
      if (!m_err && !step_mode) m_halt = 0;
      else if (!m_err && rise) begin m_halt = 0; m_step = 1; end
    end else if (k == K_STALL) begin
      m_waited = m_wait ? m_waited + 1 : 1;
      m_step = 0;
      if (m_waited >= TO) begin m_err = 1; m_halt = 1; m_wait = 0; end
      else m_wait = 1;
    end else begin
      m_halt = step_mode || (m_step && !m_wait);
      m_wait = 0;
      m_step = 0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_ctl", 64'({en_PC, en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB, flush_IF_ID, flush_ID_EX, flush_MEM_WB}), 64'd0);
    chk("rst_mem_err", 64'(mem_err), 64'd0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    idle_in();
    step_mode = 0;
    step_go = 0;
    @(negedge clk);
    do_reset();
    cyc("normal");
    mem_read_EX = 1; rd_EX = 5; rs1_ID = 5; rs1_used_ID = 1;
    cyc("load_use");
    chk("load_use_pc", 64'(pc_hits), 64'd1);
    mem_read_EX = 0;
    cyc("after_lu");
    mem_read_EX = 1; br_taken_EX = 1;
    cyc("br_over_lu");
    idle_in();
    rs1_ID = 3; rd_EX = 3; mem_read_EX = 1; rs1_used_ID = 0;
    cyc("lu_unused_rs");
    rs1_ID = 0; rd_EX = 0; rs1_used_ID = 1;
    cyc("lu_x0");
    idle_in();
    mem_req_MEM = 1;
    repeat (3) cyc("mem_wait");
    mem_ready_MEM = 1;
    cyc("mem_done");
    idle_in();
    cyc("mem_after");
    chk("mem_run", 64'(halted), 64'd0);
    step_mode = 1;
    cyc("step_enter");
    repeat (2) cyc("halt_idle");
    pc_hits = 0;
    step_go = 1;
    repeat (5) cyc("step_go_held");
    chk("step_once", 64'(pc_hits), 64'd1);
    step_go = 0;
    cyc("step_go_low");
    step_mode = 0;
    repeat (2) cyc("step_exit");
    for (int i = 0; i < 400; i++) begin
      rs1_ID = 5'($urandom_range(0, 7));
      rs2_ID = 5'($urandom_range(0, 7));
      rd_EX = 5'($urandom_range(0, 7));
      rs1_used_ID = 1'($urandom_range(0, 1));
      rs2_used_ID = 1'($urandom_range(0, 1));
      mem_read_EX = 1'($urandom_range(0, 1));
      br_taken_EX = $urandom_range(0, 4) == 0;
      mem_req_MEM = $urandom_range(0, 9) < 3;
      mem_ready_MEM = $urandom_range(0, 9) < 7;
      if ($urandom_range(0, 19) == 0) step_mode = ~step_mode;
      step_go = $urandom_range(0, 9) < 3;
      cyc("rand");
    end
    idle_in();
    step_mode = 0;
    step_go = 0;
    @(negedge clk);
    do_reset();
    mem_req_MEM = 1;
    repeat (TO) cyc("timeout_wait");
    chk("timeout_err", 64'(mem_err), 64'd1);
    chk("timeout_halt", 64'(halted), 64'd1);
    step_mode = 1;
    for (int i = 0; i < 6; i++) begin
      step_go = 1'(i & 1);
      cyc("timeout_sticky");
    end
    step_mode = 0;
    step_go = 0;
    cyc("timeout_stuck");
    do_reset();
    idle_in();
    mem_req_MEM = 1;
    repeat (2) cyc("pre_async");
    #2;
    rst = 1'b1;
    #1;
    chk("async_ctl", 64'({en_PC, en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB, flush_IF_ID, flush_ID_EX, flush_MEM_WB}), 64'd0);
    chk("async_err", 64'(mem_err), 64'd0);
    chk("async_stall_cnt", 64'(stall_cnt), 64'd0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    idle_in();
    cyc("post_async");
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central sequencer for the 5-stage pipeline. It generates enable and flush controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers. Sources of control:
- load-use hazards
- taken branches/jumps resolved in EX
- multi-cycle data-memory waits, with a timeout watchdog
- a debug single-step mode

It sits beside the datapath and drives only register enables and clears; it never touches data.

Parameters:
MEM_TIMEOUT, 16, max consecutive MEM_WAIT cycles before mem_err (1..255)
CNT_W, 32, width of optional performance counters

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
rs1_ID  in  5  rs1 field of instruction in ID
rs2_ID  in  5  rs2 field of instruction in ID
rs1_used_ID  in  1  ID instruction reads rs1
rs2_used_ID  in  1  ID instruction reads rs2
rd_EX  in  5  destination of instruction in EX
mem_read_EX  in  1  EX instruction is a load
br_taken_EX  in  1  EX instruction redirects PC
mem_req_MEM  in  1  MEM instruction accesses data memory
mem_ready_MEM  in  1  data memory completes access this cycle
step_mode  in  1  debug: pipeline halts between steps
step_go  in  1  debug: level, rising edge requests one step
en_PC  out  1  PC update enable
en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB  out  1 each  stage register enables
flush_IF_ID, flush_ID_EX, flush_MEM_WB  out  1 each  synchronous clear (bubble) of stage register
halted  out  1  FSM in HALT
mem_err  out  1  sticky memory-timeout flag
stall_cnt, flush_cnt  out  CNT_W each  performance counters (optional feature)

Behaviour:
- States: RUN, MEM_WAIT, HALT, STEP. On rst: state=RUN, timeout counter=0, mem_err=0, step_go edge register=0, counters=0.
- While rst is high, all enables=0 and all flushes=0.
- Outputs are combinational from state and current inputs. Flush has priority over enable inside the stage registers.
- load_use = mem_read_EX & rd_EX!=0 & ((rs1_used_ID & rs1_ID==rd_EX) | (rs2_used_ID & rs2_ID==rd_EX)).
- mem_stall = mem_req_MEM & ~mem_ready_MEM.
- Priority in RUN/STEP: mem_stall > br_taken_EX > load_use > normal.
  - mem_stall: en_PC, en_IF_ID, en_ID_EX, en_EX_MEM = 0; flush_MEM_WB=1, en_MEM_WB=1. Next state MEM_WAIT; counter loads 1.
  - br_taken_EX: all enables 1; flush_IF_ID=1, flush_ID_EX=1. A simultaneous load_use is ignored.
  - load_use: en_PC=0, en_IF_ID=0; flush_ID_EX=1; en_EX_MEM=1, en_MEM_WB=1.
  - normal: all enables 1, no flush.
- MEM_WAIT:
  - Outputs are identical to the mem_stall case while mem_ready_MEM=0; counter increments.
  - mem_ready_MEM=1: behave as RUN for this cycle, using RUN priorities; the held branch/load_use is acted on now. Next state RUN, or HALT if step_mode.
  - Counter reaching MEM_TIMEOUT with ready still 0: mem_err<=1 (sticky until rst), next HALT.
- HALT:
  - All enables 0, no flushes.
  - Exit on step_go rising edge (registered previous value): go to STEP if step_mode=1 and mem_err=0.
  - If step_mode=0 and mem_err=0, return to RUN.
  - While mem_err=1, stay in HALT.
- STEP: exactly one RUN-equivalent cycle. Next state HALT, or MEM_WAIT if mem_stall; after that wait completes, go to HALT.
- In RUN with step_mode=1 and no mem_stall: next state HALT. The current cycle still advances.
- step_go held high does not retrigger a step; a new rising edge is required.
- rs/rd index 0 never produces a hazard.

Optional Feature:
PIPE_PERF_CNT_EN
- Defined:
  - stall_cnt increments each cycle en_PC=0 while not in HALT.
  - flush_cnt increments each cycle flush_IF_ID or flush_ID_EX is 1.
  - Both are CNT_W wide, wrap at 2^CNT_W, and reset to 0.
- Undefined: stall_cnt and flush_cnt are tied to 0 and no counter registers are built.

Test Plan:
- Load-use: mem_read_EX=1, rd_EX=5, rs1_ID=5, rs1_used_ID=1 for 1 cycle -> en_PC=0, en_IF_ID=0, flush_ID_EX=1 that cycle; next cycle (mem_read_EX=0) all enables 1.
- Branch beats load-use: br_taken_EX=1 with the load-use condition above -> flush_IF_ID=1, flush_ID_EX=1, en_PC=1.
- Memory wait: mem_req_MEM=1, ready low 3 cycles then high -> 3 cycles with en_EX_MEM=0, flush_MEM_WB=1; 4th cycle all enables 1; state RUN.
- Timeout (MEM_TIMEOUT=4): ready never asserted -> mem_err=1 after 4th wait cycle, halted=1; step_go toggling has no effect until rst.
- Single-step: step_mode=1 from RUN -> HALT next cycle; step_go 0->1 held 5 cycles -> exactly one cycle with en_PC=1, then halted=1.
- Async reset mid-MEM_WAIT: assert rst between clock edges -> all enables 0 immediately; after release, state RUN, mem_err=0; with PIPE_PERF_CNT_EN, stall_cnt=0.
